// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: data width, register address width and
// the writeback-buffer entry layout.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // One queued writeback: destination register plus the value to write
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer. Storage plus head/tail/count bookkeeping; every
// entry is exposed so the parent can search it for operand forwarding.
// Entries at offsets [0, count) from head are the valid ones, oldest first.
module wb_fifo import riscv_pkg::*; #(
  parameter int  XLEN  = riscv_pkg::XLEN,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
)(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_push,
  input  logic [REG_ADDR_WIDTH-1:0]             i_rd,
  input  logic [XLEN-1:0]                       i_data,
  input  logic                                  i_pop,
  output logic [CW-1:0]                         o_count,
  output logic [PW-1:0]                         o_head,
  output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0]  o_ent_rd,
  output logic [DEPTH-1:0][XLEN-1:0]            o_ent_data
);

  logic [PW-1:0]                        r_head;
  logic [PW-1:0]                        r_tail;
  logic [CW-1:0]                        r_count;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] r_rd;
  logic [DEPTH-1:0][XLEN-1:0]           r_data;

  logic w_push;
  logic w_pop;

  // A full buffer refuses pushes even when it is also popping this cycle
  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; validity is carried entirely by head/count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= i_rd;
      r_data[r_tail] <= i_data;
    end
  end

  assign o_count    = r_count;
  assign o_head     = r_head;
  assign o_ent_rd   = r_rd;
  assign o_ent_data = r_data;

endmodule

// File: rtl/reg_wb_driver.sv
// Writeback driver between the pipeline and the register file. Buffers
// writebacks in an in-order FIFO, drains one per cycle unless held, and
// resolves decode operands against queued writes.
// Build option: REG_WB_BYPASS_EN -- when defined, operands are forwarded from
// the youngest matching queued entry; when undefined, a match raises hazard.
module reg_wb_driver import riscv_pkg::*; #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      drain_hold,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd,
  output logic [XLEN-1:0]           rf_wd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2,
  input  logic [XLEN-1:0]           rf_data1,
  input  logic [XLEN-1:0]           rf_data2,
  output logic [XLEN-1:0]           op_a,
  output logic [XLEN-1:0]           op_b,
  output logic                      hazard
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int NPORTS = 2;

  logic [CW-1:0]                        w_count;
  logic [PW-1:0]                        w_head;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] w_ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]           w_ent_data;
  logic                                 w_push;

  // Writes to x0 are accepted and dropped so they never occupy a slot
  assign wb_ready = (w_count < CW'(DEPTH));
  assign w_push   = wb_valid && wb_ready && (wb_rd != '0);
  assign rf_we    = (w_count != '0) && !drain_hold;
  assign rf_rd    = w_ent_rd[w_head];
  assign rf_wd    = w_ent_data[w_head];

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_rd       (wb_rd),
    .i_data     (wb_data),
    .i_pop      (rf_we),
    .o_count    (w_count),
    .o_head     (w_head),
    .o_ent_rd   (w_ent_rd),
    .o_ent_data (w_ent_data)
  );

  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  logic [NPORTS-1:0][REG_ADDR_WIDTH-1:0] w_rs;
  logic [NPORTS-1:0][XLEN-1:0]           w_rfd;
  logic [NPORTS-1:0][XLEN-1:0]           w_op;
  logic [NPORTS-1:0]                     w_hit;

  assign w_rs  = {rs2, rs1};
  assign w_rfd = {rf_data2, rf_data1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic w_match;
`ifdef REG_WB_BYPASS_EN
    logic [XLEN-1:0] w_byp;

    // Scan oldest to youngest so the youngest matching entry wins
    always_comb begin
      w_match = 1'b0;
      w_byp   = '0;
      for (int k = 0; k < DEPTH; k++) begin
        automatic logic [PW-1:0] idx = w_head + PW'(k);
        if ((CW'(k) < w_count) && (w_ent_rd[idx] == w_rs[p])) begin
          w_match = 1'b1;
          w_byp   = w_ent_data[idx];
        end
      end
    end

    assign w_op[p]  = (w_rs[p] == '0) ? '0 : (w_match ? w_byp : w_rfd[p]);
    assign w_hit[p] = 1'b0;
`else
    // Any valid queued entry for this register means the file copy is stale
    always_comb begin
      w_match = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        automatic logic [PW-1:0] idx = w_head + PW'(k);
        if ((CW'(k) < w_count) && (w_ent_rd[idx] == w_rs[p])) w_match = 1'b1;
      end
    end

    assign w_op[p]  = (w_rs[p] == '0) ? '0 : w_rfd[p];
    assign w_hit[p] = (w_rs[p] != '0) && w_match;
`endif
  end

  assign op_a   = w_op[0];
  assign op_b   = w_op[1];
  assign hazard = |w_hit;

endmodule

// File: tb/tb_reg_wb_driver.sv
// Self-checking bench for reg_wb_driver: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_reg_wb_driver;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
`ifdef REG_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        drain_hold;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [4:0]  rs1, rs2, rf_rs1, rf_rs2;
  logic [31:0] rf_data1, rf_data2, op_a, op_b;
  logic        hazard;

  int n_vec = 0;
  int n_bad = 0;

  wb_entry_t q[$];
  bit        m_we;

  always #5 clk = ~clk;

  reg_wb_driver #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .drain_hold(drain_hold),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .rs1(rs1), .rs2(rs2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .op_a(op_a), .op_b(op_b), .hazard(hazard)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference operand: zero for x0, else youngest queued write, else file
  function automatic void resolve(input logic [4:0] rs, input logic [31:0] rfd,
                                  output logic [31:0] op, output logic hit);
    hit = 1'b0;
    op  = rfd;
    if (rs == 5'd0) begin
      op = '0;
      return;
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rd == rs) begin
        hit = 1'b1;
        if (BYP) op = q[i].data;
        break;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic h, input logic [4:0] a, input logic [4:0] b);
    wb_valid   = v;
    wb_rd      = rd;
    wb_data    = d;
    drain_hold = h;
    rs1        = a;
    rs2        = b;
    rf_data1   = $urandom;
    rf_data2   = $urandom;
  endtask

  task automatic settle_check();
    logic [31:0] ea, eb;
    logic        ha, hb;
    int          n;
    #2;
    n    = q.size();
    m_we = (n != 0) && !drain_hold;
    chk("wb_ready", 32'(wb_ready), 32'(n < DEPTH));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(q[0].rd));
      chk("rf_wd", rf_wd, q[0].data);
    end
    chk("rf_rs1", 32'(rf_rs1), 32'(rs1));
    chk("rf_rs2", 32'(rf_rs2), 32'(rs2));
    resolve(rs1, rf_data1, ea, ha);
    resolve(rs2, rf_data2, eb, hb);
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("hazard", 32'(hazard), 32'(!BYP && (ha || hb)));
  endtask

  task automatic tick();
    logic      push;
    wb_entry_t e;
    push   = wb_valid && (q.size() < DEPTH) && (wb_rd != 5'd0);
    e.rd   = wb_rd;
    e.data = wb_data;
    @(posedge clk);
    if (m_we) void'(q.pop_front());
    if (push) q.push_back(e);
    #1;
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic h, input logic [4:0] a, input logic [4:0] b);
    drive(v, rd, d, h, a, b);
    settle_check();
    tick();
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0);
    settle_check();
    chk("rst_op_a", op_a, rf_data1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd4);

    // Single write held, then observed by decode, then drained
    step(1'b1, 5'd3, 32'hAB, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0);
    settle_check();
`ifdef REG_WB_BYPASS_EN
    chk("byp_op_a", op_a, 32'hAB);
`else
    chk("hz_rs1", 32'(hazard), 32'd1);
`endif
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    settle_check();
    chk("drain_we", 32'(rf_we), 32'd1);
    chk("drain_rd", 32'(rf_rd), 32'd3);
    chk("drain_wd", rf_wd, 32'hAB);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    settle_check();
    chk("one_shot_we", 32'(rf_we), 32'd0);
    tick();

    // Write to x0 is swallowed
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    settle_check();
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_op_a", op_a, 32'd0);
    tick();

    // Fill to capacity with drain held, then release
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 32'(i * 16), 1'b1, 5'(i), 5'd2);
    drive(1'b1, 5'd5, 32'd80, 1'b1, 5'd0, 5'd0);
    settle_check();
    chk("full_ready", 32'(wb_ready), 32'd0);
    tick();
    step(1'b1, 5'd5, 32'd80, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd5, 32'd80, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd1);

    // Duplicate destinations coexist; youngest forwards, oldest drains first
    step(1'b1, 5'd7, 32'd1, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'd2, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7);
    settle_check();
`ifdef REG_WB_BYPASS_EN
    chk("dup_op_b", op_b, 32'd2);
`else
    chk("dup_hz", 32'(hazard), 32'd1);
`endif
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);
    settle_check();
    chk("dup_first", rf_wd, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);
    settle_check();
    chk("dup_second", rf_wd, 32'd2);
    tick();

    // Mid-cycle reset with three entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_we", 32'(rf_we), 32'd0);
    chk("arst_hz", 32'(hazard), 32'd0);
    chk("arst_ready", 32'(wb_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("arst_we_edge", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd11);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
